// File: rtl/axis_pkt_checker_pkg.sv
// Shared constants for the AXI4-Stream packet checker: FSM encoding,
// expected header words, error-vector bit positions and tuser field offsets.
package axis_pkt_checker_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_HDR0    = 2'd0;
  localparam logic [1:0] ST_HDR1    = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  // Header words emitted by the packet generator
  localparam logic [63:0] HDR0_WORD = 64'hEFBEFECAFECAFECA;
  localparam logic [63:0] HDR1_WORD = 64'h00000008EFBEEFBE;

  // Bit positions inside err_flags and the per-packet error vector
  localparam int ERR_HDR   = 0;
  localparam int ERR_DATA  = 1;
  localparam int ERR_SHORT = 2;
  localparam int ERR_LONG  = 3;
  localparam int ERR_STRB  = 4;
  localparam int ERR_W     = 5;

  // tuser field holding the destination port
  localparam int TUSER_DST_LO = 24;
  localparam int TUSER_DST_HI = 31;

  // Payload beat k carries its index replicated into every byte
  function automatic logic [63:0] payload_word(input logic [7:0] idx);
    return {8{idx}};
  endfunction

endpackage

// File: rtl/axis_pkt_checker_sat_counter32.sv
// 32-bit saturating event counter. A clear that coincides with an increment
// leaves the counter at 1 so the coincident event is not lost.
module sat_counter32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        clr,
  output logic [31:0] cnt
);

  // Count up on inc, hold at all-ones, restart from the current event on clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= {31'b0, inc};
    end else if (inc && (cnt != 32'hFFFF_FFFF)) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/axis_pkt_checker.sv
// Receive-side checker for generator-format AXI4-Stream frames.
// Handshake: a beat transfers on a rising clock edge where s_axis_tvalid and
// s_axis_tready are both high; tdata/tlast/tstrb/tuser are only looked at on
// such beats, and tready depends only on the phase register and stall_mask.
module axis_pkt_checker
  import axis_pkt_checker_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH = 64,
  parameter int C_USER_WIDTH      = 128,
  parameter int C_PAYLOAD_WORDS   = 32
) (
  input  logic                           axi_aclk,
  input  logic                           axi_resetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [C_USER_WIDTH-1:0]        s_axis_tuser,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  input  logic [7:0]                     stall_mask,
  input  logic                           clear_stats,
  output logic                           pkt_done,
  output logic [31:0]                    pkt_good_cnt,
  output logic [31:0]                    pkt_bad_cnt,
  output logic [ERR_W-1:0]               err_flags,
  output logic [7:0]                     last_dst_port,
  output logic [1:0]                     dbg_state
);

  if (C_AXIS_DATA_WIDTH != 64) begin : g_width_check
    $error("axis_pkt_checker supports only C_AXIS_DATA_WIDTH = 64");
  end

  localparam logic [7:0] LAST_IDX = 8'(C_PAYLOAD_WORDS - 1);

  logic [2:0]       phase;
  logic [1:0]       state, state_nxt;
  logic [7:0]       idx, idx_nxt;
  logic [ERR_W-1:0] pkt_err, beat_err;
  logic [7:0]       dst_q, dst_now, tuser_dst;
  logic             beat, complete;
  logic             unused_tuser;

  assign tuser_dst     = s_axis_tuser[TUSER_DST_HI:TUSER_DST_LO];
  assign unused_tuser  = ^{s_axis_tuser[C_USER_WIDTH-1:TUSER_DST_HI+1],
                           s_axis_tuser[TUSER_DST_LO-1:0]};
  // Held low while reset is asserted so nothing is accepted during reset
  assign s_axis_tready = axi_resetn & ~stall_mask[phase];
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign dst_now       = (state == ST_HDR0) ? tuser_dst : dst_q;
  assign dbg_state     = state;

  // Per-beat classification: next FSM state, payload index and error vector
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    beat_err  = pkt_err;
    complete  = 1'b0;
    if (beat) begin
      if (s_axis_tstrb != '1) beat_err[ERR_STRB] = 1'b1;
      case (state)
        ST_HDR0: begin
          if (s_axis_tdata != HDR0_WORD) beat_err[ERR_HDR] = 1'b1;
          if (s_axis_tlast) begin
            beat_err[ERR_SHORT] = 1'b1;
            complete            = 1'b1;
          end else begin
            state_nxt = ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (s_axis_tdata != HDR1_WORD) beat_err[ERR_HDR] = 1'b1;
          if (s_axis_tlast) begin
            beat_err[ERR_SHORT] = 1'b1;
            complete            = 1'b1;
            state_nxt           = ST_HDR0;
          end else begin
            state_nxt = ST_PAYLOAD;
            idx_nxt   = 8'd0;
          end
        end
        ST_PAYLOAD: begin
          if (s_axis_tdata != payload_word(idx)) beat_err[ERR_DATA] = 1'b1;
          if (s_axis_tlast) begin
            if (idx != LAST_IDX) beat_err[ERR_SHORT] = 1'b1;
            complete  = 1'b1;
            state_nxt = ST_HDR0;
          end else if (idx == LAST_IDX) begin
            beat_err[ERR_LONG] = 1'b1;
            state_nxt          = ST_DRAIN;
          end else begin
            idx_nxt = idx + 8'd1;
          end
        end
        default: begin
          if (s_axis_tlast) begin
            complete  = 1'b1;
            state_nxt = ST_HDR0;
          end
        end
      endcase
    end
  end

  // FSM, phase counter, per-packet state and completion-time statistics
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      phase         <= '0;
      state         <= ST_HDR0;
      idx           <= '0;
      pkt_err       <= '0;
      dst_q         <= '0;
      pkt_done      <= 1'b0;
      err_flags     <= '0;
      last_dst_port <= '0;
    end else begin
      phase    <= phase + 3'd1;
      state    <= state_nxt;
      idx      <= idx_nxt;
      pkt_err  <= complete ? '0 : beat_err;
      pkt_done <= complete;
      if (beat && (state == ST_HDR0)) dst_q <= tuser_dst;
      if (complete) last_dst_port <= dst_now;
      err_flags <= (clear_stats ? '0 : err_flags) | (complete ? beat_err : '0);
    end
  end

  sat_counter32 u_good_cnt (
    .clk   (axi_aclk),
    .rst_n (axi_resetn),
    .inc   (complete & (beat_err == '0)),
    .clr   (clear_stats),
    .cnt   (pkt_good_cnt)
  );

  sat_counter32 u_bad_cnt (
    .clk   (axi_aclk),
    .rst_n (axi_resetn),
    .inc   (complete & (beat_err != '0)),
    .clr   (clear_stats),
    .cnt   (pkt_bad_cnt)
  );

endmodule
